uart_loopback_checker: RTL and testbench
========================================

# uart_loopback_checker

Parametrised loopback scoreboard sitting between the UART transmitter's completion strobe and the receiver's data-ready strobe in the loopback test top. Every word reported sent is queued in an in-order expected-FIFO. Every word received is popped and compared against it. Matches and errors are counted, lost frames are detected by timeout, and each error event is recorded into a readable error log, replacing the single write-address logging memory of the previous top.

## Interface
Parameters:
- `DATA_W`, 8, frame data width
- `DEPTH`, 16, expected-FIFO depth and error-log depth (power of two)
- `ADDR_W`, 4, log2(DEPTH)
- `TIMEOUT`, 2000, clocks a queued word may wait for its echo before it is declared lost (≥ 2)
- `CNT_W`, 16, width of the match/error counters

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: synchronous, active-high
- `tx_data` in DATA_W: word just transmitted, sampled when tx_done=1
- `tx_done` in 1: 1-cycle pulse, frame left the line
- `rx_data` in DATA_W: received word, sampled when rx_ready=1
- `rx_ready` in 1: 1-cycle pulse, frame received
- `clear` in 1: synchronous soft clear, same effect as reset
- `log_raddr` in ADDR_W: error-log read address
- `log_exp` out DATA_W: logged expected word (registered read)
- `log_got` out DATA_W: logged received word, 0 for lost entries
- `log_kind` out 2: 01 mismatch, 10 lost (timeout), 11 unexpected rx
- `log_count` out ADDR_W+1: valid log entries, saturates at DEPTH
- `pending` out ADDR_W+1: expected-FIFO occupancy, 0..DEPTH
- `match_cnt` out CNT_W: saturating count of matching pairs
- `err_cnt` out CNT_W: saturating count of mismatch + lost + unexpected events
- `err_pulse` out 1: 1-cycle strobe per error event
- `overflow` out 1: sticky, a push was dropped because the FIFO was full
- `timeout_flag` out 1: sticky, at least one lost frame

## Operation
- **Expected-FIFO**
  - Circular buffer with ADDR_W-bit rd/wr pointers that wrap DEPTH-1→0, plus an ADDR_W+1 count.
  - Push on tx_done when count<DEPTH.
  - Push when count=DEPTH: word dropped, `overflow` set, count unchanged.
- **Events on each clock.** At most one pop-event is resolved per cycle, in this priority:
  - rx_ready & count>0: pop the head.
    - rx_data==head → match_cnt+1.
    - Otherwise → mismatch error, log {head, rx_data, 01}.
  - rx_ready & count=0: unexpected error, log {0, rx_data, 11}. Nothing is popped.
  - Timer expiry (no rx_ready): pop the head as lost, log {head, 0, 10}, set `timeout_flag`.
- **Simultaneous push and pop**
  - A push in the same cycle as a pop is applied, and count is unchanged.
  - Compare/lost logic uses the pre-edge head. A same-cycle push is never compared in that cycle.
  - tx_done & rx_ready with count=0: the rx is unexpected, and tx_data is pushed (count→1).
  - Push while full and pop in the same cycle: the push succeeds (count stays DEPTH), and `overflow` is not set.
- **Timeout FSM.** Two states, IDLE and WAIT.
  - IDLE (count=0): timer held at 0.
  - IDLE→WAIT when a push makes count nonzero; timer=0.
  - In WAIT the timer increments every cycle.
  - Expiry when timer=TIMEOUT-1.
  - Timer reloads to 0 on every pop (match, mismatch or lost).
  - WAIT→IDLE when a pop leaves count=0 with no same-cycle push.
- **Counters.** match_cnt and err_cnt saturate at 2^CNT_W-1 and never wrap.
- **Error log**
  - DEPTH-entry RAM of {exp, got, kind}.
  - Write address = log_count[ADDR_W-1:0]. Written on each error while log_count<DEPTH.
  - When full, further errors are still counted and pulsed but not logged; there is no wrap.
  - Read: log_* reflect entry log_raddr one clock after the address is presented. Reading an unwritten entry returns 0s.
- **reset / clear**
  - FIFO pointers, count, timer, FSM (→IDLE), log_count, counters, sticky flags and err_pulse all go to 0.
  - Log RAM contents are not cleared but become invalid (log_count=0).
  - Read outputs are 0 after reset.
  - Reset mid-wait abandons queued words, and no lost events are reported for them.

## Timing
- All outputs are registered.
- Effects of tx_done/rx_ready/expiry in cycle N are visible on pending, counters, flags and log_count in cycle N+1.
- err_pulse is high exactly in cycle N+1 for an error resolved in cycle N.
- A word pushed at cycle N with no rx expires at cycle N+TIMEOUT, and the lost error is visible at N+TIMEOUT+1.
- tx_done/rx_ready held high for k cycles count as k events; upstream guarantees 1-cycle pulses.
- Log read latency is 1 cycle. A write and a read of the same address in the same cycle returns the old data.

## Test plan
- **In-order echo.** Push 0x41, 0x42, 0x43; return the same values via rx_ready 10 clocks apart. Expect match_cnt=3, err_cnt=0, pending=0, err_pulse never high.
- **Mismatch.** Push 0x55; rx 0x54. Expect err_cnt=1, log_count=1, entry 0 = {0x55, 0x54, 01}, err_pulse high one cycle after rx_ready.
- **Full/overflow.** Push 17 words with DEPTH=16. Expect pending=16, overflow=1. Drain with 16 matching rx: match_cnt=16, read pointer wrapped to 0, pending=0. Then push while full and rx in the same cycle: pending stays 16, overflow unchanged.
- **Timeout.** TIMEOUT=20. Push 0xA5 and send no rx. Expect at cycle +21 err_cnt=1, timeout_flag=1, entry {0xA5, 0x00, 10}, pending=0, FSM in IDLE. rx_ready coincident with the expiry cycle → compared, not lost.
- **Unexpected and simultaneous.** With an empty FIFO, assert tx_done(0x10) and rx_ready(0x10) together. Expect an unexpected entry {0, 0x10, 11}, pending=1. A following rx 0x10 → match_cnt=1.
- **Saturation/log-full/reset.** CNT_W=4: 20 mismatches → err_cnt=15, log_count=16 with 16 entries logged. Pulse reset with 3 words pending → all outputs 0 next cycle, and no lost events afterwards.

Source files
------------

// File: rtl/uart_loopback_checker.sv
// rtl/uart_loopback_checker.sv - loopback scoreboard: expected-FIFO, lost-frame timeout, counters, error log
module uart_loopback_checker #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 2000,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              clear,
  input  logic [ADDR_W-1:0] log_raddr,
  output logic [DATA_W-1:0] log_exp,
  output logic [DATA_W-1:0] log_got,
  output logic [1:0]        log_kind,
  output logic [ADDR_W:0]   log_count,
  output logic [ADDR_W:0]   pending,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_pulse,
  output logic              overflow,
  output logic              timeout_flag
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     log_count_q, log_count_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d, err_cnt_q, err_cnt_d;
  logic                err_pulse_q, err_pulse_d;
  logic                overflow_q, overflow_d;
  logic                timeout_flag_q, timeout_flag_d;
  logic [DATA_W-1:0]   log_exp_q, log_exp_d, log_got_q, log_got_d;
  logic [1:0]          log_kind_q, log_kind_d;

  logic [DATA_W-1:0]   fifo_mem    [DEPTH];
  logic [DATA_W-1:0]   log_exp_mem [DEPTH];
  logic [DATA_W-1:0]   log_got_mem [DEPTH];
  logic [1:0]          log_kind_mem[DEPTH];

  logic [DATA_W-1:0]   head;
  logic                fifo_empty, fifo_full, hit, expire, pop, push, is_match, err_event, log_we;
  logic [DATA_W-1:0]   ev_exp, ev_got;
  logic [1:0]          ev_kind;

  always_comb begin
    head       = fifo_mem[rd_ptr_q];
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL);
    hit        = rx_ready && !fifo_empty;
    expire     = (state_q == S_WAIT) && (timer_q == T_LAST) && !rx_ready && !fifo_empty;
    pop        = hit || expire;
    is_match   = hit && (rx_data == head);
    err_event  = (hit && !is_match) || (rx_ready && fifo_empty) || expire;
    // A pop frees a slot this cycle, so a push into a full FIFO still lands.
    push       = tx_done && (!fifo_full || pop);
    log_we     = err_event && (log_count_q < FULL);

    ev_exp  = head;
    ev_got  = '0;
    ev_kind = 2'b10;
    if (hit) begin
      ev_got  = rx_data;
      ev_kind = 2'b01;
    end else if (rx_ready) begin
      ev_exp  = '0;
      ev_got  = rx_data;
      ev_kind = 2'b11;
    end

    rd_ptr_d       = rd_ptr_q + ADDR_W'(pop);
    wr_ptr_d       = wr_ptr_q + ADDR_W'(push);
    count_d        = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
    log_count_d    = log_count_q + (ADDR_W + 1)'(log_we);
    match_cnt_d    = (is_match && (match_cnt_q != '1)) ? match_cnt_q + CNT_W'(1) : match_cnt_q;
    err_cnt_d      = (err_event && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    err_pulse_d    = err_event;
    overflow_d     = overflow_q || (tx_done && fifo_full && !pop);
    timeout_flag_d = timeout_flag_q || expire;

    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (push) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pop) begin
          timer_d = '0;
          if (count_d == '0) state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // Entries at or beyond log_count are stale or unwritten and read as zero.
    log_exp_d  = '0;
    log_got_d  = '0;
    log_kind_d = '0;
    if ({1'b0, log_raddr} < log_count_q) begin
      log_exp_d  = log_exp_mem[log_raddr];
      log_got_d  = log_got_mem[log_raddr];
      log_kind_d = log_kind_mem[log_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      log_count_q    <= '0;
      match_cnt_q    <= '0;
      err_cnt_q      <= '0;
      err_pulse_q    <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_flag_q <= 1'b0;
      log_exp_q      <= '0;
      log_got_q      <= '0;
      log_kind_q     <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      log_count_q    <= log_count_d;
      match_cnt_q    <= match_cnt_d;
      err_cnt_q      <= err_cnt_d;
      err_pulse_q    <= err_pulse_d;
      overflow_q     <= overflow_d;
      timeout_flag_q <= timeout_flag_d;
      log_exp_q      <= log_exp_d;
      log_got_q      <= log_got_d;
      log_kind_q     <= log_kind_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= tx_data;
    if (log_we) begin
      log_exp_mem[log_count_q[ADDR_W-1:0]]  <= ev_exp;
      log_got_mem[log_count_q[ADDR_W-1:0]]  <= ev_got;
      log_kind_mem[log_count_q[ADDR_W-1:0]] <= ev_kind;
    end
  end

  assign log_exp      = log_exp_q;
  assign log_got      = log_got_q;
  assign log_kind     = log_kind_q;
  assign log_count    = log_count_q;
  assign pending      = count_q;
  assign match_cnt    = match_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign err_pulse    = err_pulse_q;
  assign overflow     = overflow_q;
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_uart_loopback_checker.sv
// tb/tb_uart_loopback_checker.sv - directed bench with queue-based scoreboard model for uart_loopback_checker
module tb_uart_loopback_checker;
  localparam int DW = 8, DEPTH = 16, AW = 4, TO = 20, CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, clear, tx_done, rx_ready;
  logic [DW-1:0] tx_data, rx_data, log_exp, log_got;
  logic [AW-1:0] log_raddr;
  logic [1:0]    log_kind;
  logic [AW:0]   log_count, pending;
  logic [CW-1:0] match_cnt, err_cnt;
  logic          err_pulse, overflow, timeout_flag;

  int checks = 0, failures = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  uart_loopback_checker #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_done(tx_done), .rx_data(rx_data),
    .rx_ready(rx_ready), .clear(clear), .log_raddr(log_raddr), .log_exp(log_exp),
    .log_got(log_got), .log_kind(log_kind), .log_count(log_count), .pending(pending),
    .match_cnt(match_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse), .overflow(overflow),
    .timeout_flag(timeout_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard model: queue of outstanding words and a deadline TO cycles after the timer last restarted.
  int q[$];
  int m_match, m_err, m_logcnt, tstart, cyc;
  bit m_pulse, m_ovf, m_tf;
  int l_exp[DEPTH], l_got[DEPTH], l_kind[DEPTH];
  int r_exp, r_got, r_kind;

  initial begin
    int sz, h, ee, eg, ek;
    bit pop, err;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset || clear) begin
        q.delete();
        m_match = 0; m_err = 0; m_logcnt = 0; m_pulse = 0; m_ovf = 0; m_tf = 0;
        r_exp = 0; r_got = 0; r_kind = 0;
      end else begin
        if (int'(log_raddr) < m_logcnt) begin
          r_exp = l_exp[log_raddr]; r_got = l_got[log_raddr]; r_kind = l_kind[log_raddr];
        end else begin
          r_exp = 0; r_got = 0; r_kind = 0;
        end
        sz = q.size(); pop = 0; err = 0; ee = 0; eg = 0; ek = 0;
        if (rx_ready && sz > 0) begin
          pop = 1; h = q.pop_front();
          if (h == int'(rx_data)) m_match = (m_match < CMAX) ? m_match + 1 : CMAX;
          else begin err = 1; ee = h; eg = int'(rx_data); ek = 1; end
        end else if (rx_ready) begin
          err = 1; ee = 0; eg = int'(rx_data); ek = 3;
        end else if (sz > 0 && cyc == tstart + TO) begin
          pop = 1; h = q.pop_front(); err = 1; ee = h; eg = 0; ek = 2; m_tf = 1;
        end
        if (pop) tstart = cyc;
        if (tx_done) begin
          if (sz < DEPTH || pop) begin
            if (sz == 0) tstart = cyc;
            q.push_back(int'(tx_data));
          end else m_ovf = 1;
        end
        m_pulse = err;
        if (err) begin
          m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
          if (m_logcnt < DEPTH) begin
            l_exp[m_logcnt] = ee; l_got[m_logcnt] = eg; l_kind[m_logcnt] = ek;
            m_logcnt++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pending", 32'(pending), q.size());
      check("match_cnt", 32'(match_cnt), m_match);
      check("err_cnt", 32'(err_cnt), m_err);
      check("err_pulse", 32'(err_pulse), 32'(m_pulse));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("timeout_flag", 32'(timeout_flag), 32'(m_tf));
      check("log_count", 32'(log_count), m_logcnt);
      check("log_exp", 32'(log_exp), r_exp);
      check("log_got", 32'(log_got), r_got);
      check("log_kind", 32'(log_kind), r_kind);
    end
  end

  task automatic pulse(input bit t, input logic [DW-1:0] td, input bit r, input logic [DW-1:0] rd);
    tx_done = t; tx_data = td; rx_ready = r; rx_data = rd;
    @(negedge clk);
    tx_done = 0; rx_ready = 0;
  endtask

  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask

  initial begin
    logic [DW-1:0] v;
    reset = 1; clear = 0; tx_done = 0; rx_ready = 0; tx_data = 0; rx_data = 0; log_raddr = 0;
    repeat (2) @(negedge clk);
    reset = 0; cmp_en = 1;
    check("rst_pending", 32'(pending), 0);
    check("rst_match", 32'(match_cnt), 0);
    check("rst_log_kind", 32'(log_kind), 0);

    // In-order echo
    pulse(1, 8'h41, 0, 8'h00); pulse(1, 8'h42, 0, 8'h00); pulse(1, 8'h43, 0, 8'h00);
    check("echo_pending3", 32'(pending), 3);
    pulse(0, 8'h00, 1, 8'h41); repeat (9) @(negedge clk);
    pulse(0, 8'h00, 1, 8'h42); repeat (9) @(negedge clk);
    pulse(0, 8'h00, 1, 8'h43);
    check("echo_match", 32'(match_cnt), 3);
    check("echo_err", 32'(err_cnt), 0);
    check("echo_pending", 32'(pending), 0);

    // Mismatch and log read
    pulse(1, 8'h55, 0, 8'h00);
    pulse(0, 8'h00, 1, 8'h54);
    check("mm_pulse", 32'(err_pulse), 1);
    check("mm_err", 32'(err_cnt), 1);
    check("mm_logcnt", 32'(log_count), 1);
    @(negedge clk);
    check("mm_pulse_off", 32'(err_pulse), 0);
    check("mm_exp", 32'(log_exp), 32'h55);
    check("mm_got", 32'(log_got), 32'h54);
    check("mm_kind", 32'(log_kind), 1);
    log_raddr = 1;
    repeat (2) @(negedge clk);
    check("mm_unwritten", 32'(log_exp), 0);

    // Full / overflow / wrap, then full push with same-cycle pop
    do_clear();
    for (int i = 0; i < 17; i++) pulse(1, 8'(8'h80 + i), 0, 8'h00);
    check("full_pending", 32'(pending), 16);
    check("full_ovf", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) pulse(0, 8'h00, 1, 8'(8'h80 + i));
    check("drain_match", 32'(match_cnt), 16);
    check("drain_pending", 32'(pending), 0);
    check("drain_err", 32'(err_cnt), 0);
    do_clear();
    for (int i = 0; i < 16; i++) pulse(1, 8'(8'hC0 + i), 0, 8'h00);
    pulse(1, 8'hD0, 1, 8'hC0);
    check("fullpp_pending", 32'(pending), 16);
    check("fullpp_ovf", 32'(overflow), 0);
    for (int i = 1; i < 17; i++) pulse(0, 8'h00, 1, 8'(8'hC0 + i));
    check("fullpp_match", 32'(match_cnt), 17);
    check("fullpp_err", 32'(err_cnt), 0);

    // Timeout, then rx landing on the expiry cycle
    do_clear();
    log_raddr = 0;
    pulse(1, 8'hA5, 0, 8'h00);
    repeat (19) @(negedge clk);
    check("to_before_err", 32'(err_cnt), 0);
    check("to_before_pending", 32'(pending), 1);
    @(negedge clk);
    check("to_err", 32'(err_cnt), 1);
    check("to_flag", 32'(timeout_flag), 1);
    check("to_pending", 32'(pending), 0);
    check("to_pulse", 32'(err_pulse), 1);
    @(negedge clk);
    check("to_exp", 32'(log_exp), 32'hA5);
    check("to_got", 32'(log_got), 0);
    check("to_kind", 32'(log_kind), 2);
    pulse(1, 8'h3C, 0, 8'h00);
    repeat (19) @(negedge clk);
    pulse(0, 8'h00, 1, 8'h3C);
    check("to_edge_match", 32'(match_cnt), 1);
    check("to_edge_err", 32'(err_cnt), 1);
    repeat (25) @(negedge clk);
    check("to_edge_quiet", 32'(err_cnt), 1);

    // Unexpected rx with simultaneous push
    do_clear();
    pulse(1, 8'h10, 1, 8'h10);
    check("unx_pending", 32'(pending), 1);
    check("unx_err", 32'(err_cnt), 1);
    @(negedge clk);
    check("unx_exp", 32'(log_exp), 0);
    check("unx_got", 32'(log_got), 32'h10);
    check("unx_kind", 32'(log_kind), 3);
    pulse(0, 8'h00, 1, 8'h10);
    check("unx_match", 32'(match_cnt), 1);

    // Saturation, log full, reset mid-wait
    do_clear();
    for (int i = 0; i < 40; i++) begin
      v = 8'(i);
      pulse(1, v, 0, 8'h00);
      pulse(0, 8'h00, 1, ~v);
    end
    check("sat_err", 32'(err_cnt), 31);
    check("sat_logcnt", 32'(log_count), 16);
    log_raddr = 15;
    repeat (2) @(negedge clk);
    check("sat_exp15", 32'(log_exp), 32'h0F);
    check("sat_got15", 32'(log_got), 32'hF0);
    check("sat_kind15", 32'(log_kind), 1);
    pulse(1, 8'h01, 0, 8'h00); pulse(1, 8'h02, 0, 8'h00); pulse(1, 8'h03, 0, 8'h00);
    check("pre_rst_pending", 32'(pending), 3);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst2_pending", 32'(pending), 0);
    check("rst2_err", 32'(err_cnt), 0);
    check("rst2_logcnt", 32'(log_count), 0);
    check("rst2_exp", 32'(log_exp), 0);
    repeat (30) @(negedge clk);
    check("rst2_quiet_err", 32'(err_cnt), 0);
    check("rst2_quiet_flag", 32'(timeout_flag), 0);
    check("rst2_stale_read", 32'(log_kind), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
